// File: rtl/seq_calc_unit.sv
// ---------------------------------------------------------------------------
// seq_calc_unit
//   Handshaked W-bit unsigned calculator producing a 2W-bit result.
//   Computes add, sub, mul and not-A in one cycle. Computes div and mod with a
//   W-step restoring divider. Illegal opcodes and division by zero are reported
//   on err. At most one operation is in flight at any time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operation present on a/b/oper
//   in_ready   operation can be accepted (IDLE only)
//   a, b       W-bit unsigned operands
//   oper       000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 not-A,
//              110/111 illegal
//   out_valid  out/err valid; held until out_ready
//   out_ready  sink accepts the result
//   out        2W-bit result
//   err        divide by zero or illegal opcode (qualified by out_valid)
//   busy       divider is iterating
//
// Configuration
//   CALC_SAT_SUB_EN  when defined, sub clamps to zero when b > a instead of
//                    wrapping in 2W bits.
// ---------------------------------------------------------------------------
module seq_calc_unit #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     oper,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out,
    output logic           err,
    output logic           busy
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_NOT = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_e;

    localparam int          CW   = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e         state;
    logic [W-1:0]   div_rem;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_dvs;
    logic [CW-1:0]  div_cnt;
    logic           div_is_mod;

    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x;
    logic [2*W-1:0] sc_result;
    logic           sc_err;
    logic           start_div;

    logic [W:0]     rem_shift;
    logic           rem_ge;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quo_next;

    assign a_x = {{W{1'b0}}, a};
    assign b_x = {{W{1'b0}}, b};

    // Single-cycle result, evaluated on the live inputs and captured on accept.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        sc_result = '0;
        sc_err    = 1'b0;
        start_div = 1'b0;
        case (op_e'(oper))
            OP_ADD: sc_result = a_x + b_x;
`ifdef CALC_SAT_SUB_EN
            OP_SUB: sc_result = (b > a) ? '0 : (a_x - b_x);
`else
            OP_SUB: sc_result = a_x - b_x;
`endif
            OP_MUL: sc_result = a_x * b_x;
            OP_DIV,
            OP_MOD: begin
                if (b == '0) sc_err    = 1'b1;
                else         start_div = 1'b1;
            end
            OP_NOT: sc_result = {{W{1'b0}}, ~a};
            default: sc_err = 1'b1;
        endcase
    end

    // One restoring-divide step: shift the next dividend bit (quotient MSB) into
    // the partial remainder, subtract the divisor when it fits, and shift the
    // resulting quotient bit into the LSB of the quotient register.
    always_comb begin
        rem_shift = {div_rem, div_quo[W-1]};
        rem_ge    = (rem_shift >= {1'b0, div_dvs});
        rem_next  = rem_ge ? W'(rem_shift - {1'b0, div_dvs}) : rem_shift[W-1:0];
        quo_next  = {div_quo[W-2:0], rem_ge};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out        <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            // NOTE: the divider datapath is cleared too; a reset mid-division
            // must leave no trace of the aborted operation.
            div_rem    <= '0;
            div_quo    <= '0;
            div_dvs    <= '0;
            div_cnt    <= '0;
            div_is_mod <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (start_div) begin
                            state      <= S_DIV;
                            busy       <= 1'b1;
                            div_rem    <= '0;
                            div_quo    <= a;
                            div_dvs    <= b;
                            div_cnt    <= '0;
                            div_is_mod <= (oper == OP_MOD);
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            out       <= sc_result;
                            err       <= sc_err;
                        end
                    end
                end

                S_DIV: begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    div_cnt <= div_cnt + 1'b1;
                    // The final step's result goes straight to the output so
                    // out_valid appears W+1 cycles after accept.
                    if (div_cnt == LAST) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        err       <= 1'b0;
                        out       <= div_is_mod ? {{W{1'b0}}, rem_next}
                                                : {{W{1'b0}}, quo_next};
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_calc_unit
//   Self-checking bench for seq_calc_unit at W=4. Stimulus pushes the expected
//   {err, out} of every accepted operation into a queue; an independent
//   monitor pops and compares whenever a result is consumed. Timing (latency,
//   busy length, in_ready) is checked alongside the stimulus.
// ---------------------------------------------------------------------------
module tb_seq_calc_unit;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     oper;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;
    logic           err;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W:0] exp_q[$];   // {err, out}
    string        name_q[$];

    logic [2*W:0] mon_exp;
    string        mon_name;

    always #5 clk = ~clk;

    seq_calc_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: compares every consumed result against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_queue_size", exp_q.size(), 1);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check({mon_name, "_out"}, out, mon_exp[2*W-1:0]);
                check({mon_name, "_err"}, err, mon_exp[2*W]);
            end
        end
    end

    // Issue one operation with out_ready high and check its timing.
    // Called just after a rising edge.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] op, input logic [2*W-1:0] eo, input logic ee,
                          input int elat, input int ebusy);
        int guard;
        int lat;
        int busy_n;
        bit seen;
        a        = av;
        b        = bv;
        oper     = op;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check({name, "_ready_wait"}, in_ready, 1);
        @(posedge clk);
        exp_q.push_back({ee, eo});
        name_q.push_back(name);
        #1 in_valid = 1'b0;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (lat == 1) check({name, "_in_ready_low"}, in_ready, 0);
            if (out_valid) seen = 1'b1;
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_busy_cycles"}, busy_n, ebusy);
        @(posedge clk);
        @(negedge clk);
        check({name, "_in_ready_back"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    acc_mask;
        int    valid_seen;
        int    guard;
        logic [2*W-1:0] exp_sub;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        oper      = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_err",       err,       0);
        check("rst_busy",      busy,      0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle operations
`ifdef CALC_SAT_SUB_EN
        exp_sub = 8'h00;
`else
        exp_sub = 8'hFE;
`endif
        run_op("add_15_15", 4'd15, 4'd15, 3'b000, 8'd30,  1'b0, 1, 0);
        run_op("sub_3_5",   4'd3,  4'd5,  3'b001, exp_sub, 1'b0, 1, 0);
        run_op("sub_9_4",   4'd9,  4'd4,  3'b001, 8'd5,   1'b0, 1, 0);
        run_op("mul_15_15", 4'd15, 4'd15, 3'b010, 8'd225, 1'b0, 1, 0);
        run_op("mul_0_7",   4'd0,  4'd7,  3'b010, 8'd0,   1'b0, 1, 0);
        run_op("not_5",     4'd5,  4'd9,  3'b101, 8'h0A,  1'b0, 1, 0);

        // Multi-cycle divider
        run_op("div_13_4",  4'd13, 4'd4,  3'b011, 8'd3,   1'b0, W + 1, W);
        run_op("mod_13_4",  4'd13, 4'd4,  3'b100, 8'd1,   1'b0, W + 1, W);
        run_op("div_15_1",  4'd15, 4'd1,  3'b011, 8'd15,  1'b0, W + 1, W);
        run_op("mod_15_15", 4'd15, 4'd15, 3'b100, 8'd0,   1'b0, W + 1, W);
        run_op("div_3_7",   4'd3,  4'd7,  3'b011, 8'd0,   1'b0, W + 1, W);
        run_op("mod_3_7",   4'd3,  4'd7,  3'b100, 8'd3,   1'b0, W + 1, W);

        // Error cases
        run_op("div_9_0",   4'd9,  4'd0,  3'b011, 8'd0,   1'b1, 1, 0);
        run_op("mod_9_0",   4'd9,  4'd0,  3'b100, 8'd0,   1'b1, 1, 0);
        run_op("illegal_7", 4'd9,  4'd3,  3'b111, 8'd0,   1'b1, 1, 0);
        run_op("illegal_6", 4'd2,  4'd3,  3'b110, 8'd0,   1'b1, 1, 0);

        // Backpressure: result held stable, new inputs ignored
        out_ready = 1'b0;
        a         = 4'd7;
        b         = 4'd6;
        oper      = 3'b010;
        in_valid  = 1'b1;
        @(posedge clk);
        exp_q.push_back({1'b0, 8'd42});
        name_q.push_back("bp_mul_7_6");
        #1;
        a    = 4'd1;
        b    = 4'd1;
        oper = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_stable", out, 8'd42);
            check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_in_ready", in_ready, 1);
        check("bp_released_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back adds with out_ready high: accepts every second cycle
        a        = 4'd5;
        b        = 4'd9;
        oper     = 3'b000;
        in_valid = 1'b1;
        acc_mask = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                acc_mask |= (1 << i);
                exp_q.push_back({1'b0, 8'd14});
                name_q.push_back("b2b_add_5_9");
            end
        end
        check("b2b_accept_pattern", acc_mask, 32'b10101);
        @(posedge clk);
        #1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("b2b_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset mid-division aborts with no result
        a        = 4'd13;
        b        = 4'd4;
        oper     = 3'b011;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy_before_rst", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready",  in_ready,  1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out",       out,       0);
        check("abort_err",       err,       0);
        check("abort_busy",      busy,      0);
        rst        = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) valid_seen++;
        end
        check("abort_no_result", valid_seen, 0);
        @(posedge clk);
        #1;

        // Divider still correct after the abort
        run_op("div_after_abort", 4'd14, 4'd3, 3'b011, 8'd4, 1'b0, W + 1, W);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
